// File: rtl/lsu_ctrl.sv
// Load/store sequencer: latches one access, checks it, runs a req/ack memory
// handshake with timeout, and returns an aligned, extended load result.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] sdata_q, sdata_d;
  logic [31:0] ld_q, ld_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [31:0] ea_s;
  logic        onehot_s;
  logic        misal_s;
  logic        is_load_s;
  logic        is_store_s;
  logic        wr_act_s;

  // Aligned, sign/zero-extended load value for the latched op and byte lane.
  function automatic logic [31:0] extract_load(input logic [7:0] o, input logic [1:0] lane,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      2'd3:    b = rd[31:24];
      default: b = rd[7:0];
    endcase
    h = lane[1] ? rd[31:16] : rd[15:0];
    if (o[0])      extract_load = {{24{b[7]}}, b};
    else if (o[1]) extract_load = {{16{h[15]}}, h};
    else if (o[3]) extract_load = {24'd0, b};
    else if (o[4]) extract_load = {16'd0, h};
    else           extract_load = rd;
  endfunction

  // Byte enables for a store of the latched op at the given lane.
  function automatic logic [3:0] store_strb(input logic [7:0] o, input logic [1:0] lane);
    if (o[5])      store_strb = 4'b0001 << lane;
    else if (o[6]) store_strb = lane[1] ? 4'b1100 : 4'b0011;
    else if (o[7]) store_strb = 4'b1111;
    else           store_strb = 4'b0000;
  endfunction

  // Store data replicated across every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [7:0] o, input logic [31:0] d);
    if (o[5])      store_wdata = {4{d[7:0]}};
    else if (o[6]) store_wdata = {2{d[15:0]}};
    else if (o[7]) store_wdata = d;
    else           store_wdata = 32'd0;
  endfunction

  assign ea_s     = base + offset;
  assign onehot_s = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
  assign misal_s  = ((op[1] | op[4] | op[6]) & ea_s[0]) |
                    ((op[2] | op[7]) & (ea_s[1:0] != 2'b00));

  assign is_load_s  = |op_q[4:0];
  assign is_store_s = |op_q[7:5];

  // State and access registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 8'd0;
      ea_q    <= 32'd0;
      sdata_q <= 32'd0;
      ld_q    <= 32'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ea_q    <= ea_d;
      sdata_q <= sdata_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a bad op or misalignment never reaches REQ.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ea_d    = ea_q;
    sdata_d = sdata_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          ea_d    = ea_s;
          sdata_d = store_data;
          cnt_d   = 8'd0;
          if (!onehot_s || misal_s) state_d = FAIL;
          else                      state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = RESP;
          if (is_load_s) ld_d = extract_load(op_q, ea_q[1:0], mem_rdata);
          else           ld_d = ld_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FAIL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_act_s  = (state_q == REQ) && is_store_s;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign err       = (state_q == FAIL);
  assign load_data = ld_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = wr_act_s;
  assign mem_addr  = (state_q == REQ) ? {ea_q[31:2], 2'b00} : 32'd0;
  assign mem_wstrb = wr_act_s ? store_strb(op_q, ea_q[1:0]) : 4'b0000;
  assign mem_wdata = wr_act_s ? store_wdata(op_q, sdata_q) : 32'd0;

endmodule
